// File: rtl/mem_pkg.sv
// Shared definitions for the mips_memory2 port initiators: access_size
// encodings, read/write strobe values, instruction-memory base address,
// and the writer FSM state type.
package mem_pkg;

  localparam logic [1:0]  ACC_1W    = 2'b00;
  localparam logic [1:0]  ACC_4W    = 2'b01;
  localparam logic [1:0]  ACC_8W    = 2'b10;
  localparam logic [1:0]  ACC_16W   = 2'b11;

  localparam logic        RW_WRITE  = 1'b1;
  localparam logic        RW_READ   = 1'b0;

  localparam logic [31:0] IMEM_BASE = 32'h8002_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_REQ,
    ST_BURST,
    ST_TAIL_WAIT,
    ST_TAIL_BEAT,
    ST_DONE
  } wr_state_t;

  // Burst length in words to access_size code; anything unrecognised is a single word.
  function automatic logic [1:0] enc(input int len);
    case (len)
      4:       enc = ACC_4W;
      8:       enc = ACC_8W;
      16:      enc = ACC_16W;
      default: enc = ACC_1W;
    endcase
  endfunction

endpackage

// File: rtl/mem_image_writer_if.sv
// Memory-side request bus of the mips_memory2 port. The initiator drives the
// request fields; the memory returns busy.
interface mem_image_writer_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;

  modport master (output addr, din, access_size, rw, enable, input busy);
  modport slave  (input addr, din, access_size, rw, enable, output busy);
endinterface

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembler. The first byte of each group of four
// lands in [31:24]. word/word_valid are combinational on the byte that
// completes a word; flush on a byte emits a partial word zero-padded low.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_p0;
  logic [23:0] sh_p0;
  logic [31:0] cat;

  // Stale high bytes of the shifter are pushed out by the left shift, so the
  // shifter itself never needs clearing.
  assign cat        = {sh_p0, byte_in};
  assign word_valid = byte_valid && (flush || (cnt_p0 == 2'd3));
  assign word       = cat << {(2'd3 - cnt_p0), 3'b000};

  // Byte position within the current word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cnt_p0 <= 2'd0;
    else if (clr)        cnt_p0 <= 2'd0;
    else if (byte_valid) cnt_p0 <= word_valid ? 2'd0 : cnt_p0 + 2'd1;
  end

  // Byte shifter (data only, no reset).
  always_ff @(posedge clk) begin
    if (byte_valid) sh_p0 <= cat[23:0];
  end

endmodule

// File: rtl/mem_image_writer.sv
// Program-image loader: packs a big-endian byte stream into words and writes
// them into instruction memory as bursts, finishing with single-word writes
// for a partial last burst. Owns the memory port while loading is high.
// Optional: define MEM_IMAGE_WRITER_CHECKSUM_EN to keep a running mod-2^32
// sum of every written word on checksum; otherwise checksum is tied to 0.
module mem_image_writer
  import mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = IMEM_BASE,
  parameter int          BURST_LEN  = 4,
  parameter int          LEN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  mem_image_writer_if.master mem,
  output logic              loading,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam int          PW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX  = PW'(BURST_LEN - 1);
  localparam logic [1:0]  ACC_BURST   = enc(BURST_LEN);
  localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);

  wr_state_t         state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [31:0]       waddr;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     ridx;
  logic [PW-1:0]     tail_last;
  logic [31:0]       wbuf [2**PW];

  logic              accept;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = in_valid && in_ready;
  assign last_byte = (remaining == LEN_W'(1));

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == ST_IDLE),
    .byte_valid (accept),
    .byte_in    (in_data),
    .flush      (last_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and port outputs; the memory bus idles at all-zero.
  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    loading         = 1'b0;
    done            = 1'b0;
    mem.enable      = 1'b0;
    mem.rw          = RW_READ;
    mem.addr        = '0;
    mem.din         = '0;
    mem.access_size = ACC_1W;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (byte_count == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        loading  = 1'b1;
        in_ready = (remaining != '0);
        if (accept && word_valid) begin
          if (wptr == LAST_IDX) state_nxt = ST_REQ;
          else if (last_byte)   state_nxt = ST_TAIL_WAIT;
        end
      end
      ST_REQ: begin
        loading = 1'b1;
        if (!mem.busy) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        loading         = 1'b1;
        mem.enable      = 1'b1;
        mem.rw          = RW_WRITE;
        mem.addr        = waddr;
        mem.din         = wbuf[ridx];
        mem.access_size = ACC_BURST;
        if (ridx == LAST_IDX) state_nxt = (remaining != '0) ? ST_FILL : ST_DONE;
      end
      ST_TAIL_WAIT: begin
        loading = 1'b1;
        if (!mem.busy) state_nxt = ST_TAIL_BEAT;
      end
      ST_TAIL_BEAT: begin
        loading    = 1'b1;
        mem.enable = 1'b1;
        mem.rw     = RW_WRITE;
        mem.addr   = waddr;
        mem.din    = wbuf[ridx];
        state_nxt  = (ridx == tail_last) ? ST_DONE : ST_TAIL_WAIT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte countdown, write address and buffer pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      waddr     <= '0;
      wptr      <= '0;
      ridx      <= '0;
      tail_last <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (byte_count != '0)) begin
            remaining <= byte_count;
            waddr     <= START_ADDR;
            wptr      <= '0;
          end
        end
        ST_FILL: begin
          ridx <= '0;
          if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (word_valid) begin
              wptr      <= (wptr == LAST_IDX) ? '0 : wptr + PW'(1);
              tail_last <= wptr;
            end
          end
        end
        ST_BURST: begin
          if (ridx == LAST_IDX) begin
            ridx  <= '0;
            waddr <= waddr + BURST_BYTES;
          end else begin
            ridx <= ridx + PW'(1);
          end
        end
        ST_TAIL_BEAT: begin
          ridx  <= ridx + PW'(1);
          waddr <= waddr + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // Word buffer (data only, no reset).
  always_ff @(posedge clk) begin
    if (accept && word_valid) wbuf[wptr] <= word;
  end

`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
  logic [31:0] cks;

  // Running sum of written words, cleared by a start taken in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cks <= '0;
    else if (state == ST_IDLE && start) cks <= '0;
    else if (mem.enable)                cks <= cks + mem.din;
  end

  assign checksum = cks;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_image_writer.sv
// Bench for mem_image_writer: directed and randomized image loads compared
// against a word-list model built from the byte image.
module tb_mem_image_writer;

  localparam int          BL   = 4;
  localparam logic [31:0] BASE = 32'h8002_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  sz;
    logic        rw;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] byte_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, loading, done;
  logic [31:0] checksum;

  logic        busy_force = 1'b0;
  logic        busy_rand = 1'b0;
  logic        rbusy = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          viol = 0;
  int          last_le = 0;

  logic [7:0]  img[$];
  beat_t       got[$];
  beat_t       exp_q[$];
  logic [31:0] exp_cks;

  mem_image_writer_if mif ();

  assign mif.busy = busy_rand ? rbusy : busy_force;

  mem_image_writer #(.START_ADDR(BASE), .BURST_LEN(BL), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_count (byte_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem        (mif),
    .loading    (loading),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rbusy = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    if (reset && mif.enable === 1'b1)
      got.push_back('{mif.addr, mif.din, mif.access_size, mif.rw, cyc});
    if (reset && in_ready === 1'b1 && loading !== 1'b1) viol++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sz_of(input int bl);
    if (bl == 1) return 2'd0;
    if (bl == 4) return 2'd1;
    if (bl == 8) return 2'd2;
    return 2'd3;
  endfunction

  // Expected write list: full bursts share one address; leftover words go
  // out singly at consecutive word addresses.
  function automatic void build_model();
    int n, nw, nfull;
    n = img.size();
    nw = (n + 3) / 4;
    nfull = (n / (4 * BL)) * BL;
    exp_q.delete();
    exp_cks = '0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] wd;
      beat_t e;
      wd = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) wd[31 - 8 * b -: 8] = img[4 * w + b];
      e.din = wd;
      e.rw  = 1'b1;
      e.cyc = 0;
      if (w < nfull) begin
        e.addr = BASE + 32'(4 * BL * (w / BL));
        e.sz   = sz_of(BL);
      end else begin
        e.addr = BASE + 32'(4 * w);
        e.sz   = 2'd0;
      end
      exp_q.push_back(e);
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
      exp_cks = exp_cks + wd;
`endif
    end
  endfunction

  function automatic logic [31:0] beat_din(input int i);
    return (got.size() > i) ? got[i].din : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] beat_addr(input int i);
    return (got.size() > i) ? got[i].addr : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] beat_sz(input int i);
    return (got.size() > i) ? 32'(got[i].sz) : 32'hDEAD_BEEF;
  endfunction

  function automatic int beat_cyc(input int i);
    return (got.size() > i) ? got[i].cyc : -1;
  endfunction

  task automatic compare_beats(input string tag);
    chk({tag, "_nbeats"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got[i].addr, exp_q[i].addr);
      chk($sformatf("%s_din%0d", tag, i), got[i].din, exp_q[i].din);
      chk($sformatf("%s_sz%0d", tag, i), 32'(got[i].sz), 32'(exp_q[i].sz));
      chk($sformatf("%s_rw%0d", tag, i), 32'(got[i].rw), 32'd1);
      if (i > 0 && exp_q[i].sz != 2'd0 && (i % BL) != 0)
        chk($sformatf("%s_contig%0d", tag, i), 32'(got[i].cyc), 32'(got[i-1].cyc + 1));
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1;
    byte_count = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, input int budget, output int last_edge);
    int i, k;
    bit ph;
    i = 0; k = 0; ph = 1'b0;
    last_edge = -1;
    while (i < img.size() && k < budget) begin
      @(negedge clk);
      k++;
      ph = gaps ? ~ph : 1'b1;
      in_valid = ph;
      in_data  = ph ? img[i] : 8'h00;
      if (ph && in_ready === 1'b1) begin
        i++;
        last_edge = cyc + 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("feed_complete", 32'(i), 32'(img.size()));
  endtask

  task automatic wait_done(input int budget, output int done_edge);
    int k;
    k = 0;
    done_edge = -1;
    while (k < budget && done_edge < 0) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) done_edge = cyc;
    end
    chk("done_seen", 32'(done_edge >= 0), 32'd1);
  endtask

  task automatic run_load(input string tag, input bit gaps);
    int le, de;
    got.delete();
    build_model();
    pulse_start(img.size());
    fork
      feed(gaps, 3000, le);
      wait_done(6000, de);
    join
    last_le = le;
    chk({tag, "_loading_at_done"}, 32'(loading), 32'd0);
    compare_beats(tag);
    chk({tag, "_checksum"}, checksum, exp_cks);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int le, de, rel, en_seen, nb, k;

    // Reset values while reset is held.
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_enable", 32'(mif.enable), 32'd0);
    chk("rst_rw", 32'(mif.rw), 32'd0);
    chk("rst_addr", mif.addr, 32'd0);
    chk("rst_din", mif.din, 32'd0);
    chk("rst_access_size", 32'(mif.access_size), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full burst, bytes 00..0F.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    run_load("full16", 1'b0);
    chk("full16_latency", 32'(beat_cyc(0)), 32'(last_le + 1));
    chk("full16_addr", beat_addr(0), 32'h8002_0000);
    chk("full16_addr3", beat_addr(3), 32'h8002_0000);
    chk("full16_size", beat_sz(0), 32'd1);
    chk("full16_w0", beat_din(0), 32'h0001_0203);
    chk("full16_w1", beat_din(1), 32'h0405_0607);
    chk("full16_w2", beat_din(2), 32'h0809_0A0B);
    chk("full16_w3", beat_din(3), 32'h0C0D_0E0F);

    // Tail after one burst.
    img.delete();
    for (int i = 0; i < 22; i++) img.push_back(8'(i));
    run_load("tail22", 1'b0);
    chk("tail22_addr4", beat_addr(4), 32'h8002_0010);
    chk("tail22_din4", beat_din(4), 32'h1011_1213);
    chk("tail22_addr5", beat_addr(5), 32'h8002_0014);
    chk("tail22_din5", beat_din(5), 32'h1415_0000);
    chk("tail22_sz5", beat_sz(5), 32'd0);

    // Same image with in_valid toggling every other cycle.
    run_load("tail22_gaps", 1'b1);

    // Busy held high for five cycles while a full burst waits.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    got.delete();
    build_model();
    busy_force = 1'b1;
    pulse_start(16);
    feed(1'b0, 500, le);
    en_seen = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      if (mif.enable !== 1'b0) en_seen++;
    end
    chk("stall_no_enable", 32'(en_seen), 32'd0);
    rel = cyc;
    busy_force = 1'b0;
    wait_done(200, de);
    compare_beats("stall");
    chk("stall_first_beat", 32'(beat_cyc(0)), 32'(rel + 1));
    chk("stall_checksum", checksum, exp_cks);

    // Zero-length image.
    repeat (2) @(negedge clk);
    got.delete();
    pulse_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_loading", 32'(loading), 32'd0);
    @(negedge clk);
    chk("zero_done_low", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("zero_no_enable", 32'(got.size()), 32'd0);
    chk("zero_checksum", checksum, 32'd0);

    // A second start while loading must not disturb the load.
    img.delete();
    for (int i = 0; i < 40; i++) img.push_back(8'($urandom));
    got.delete();
    build_model();
    pulse_start(40);
    fork
      feed(1'b1, 3000, le);
      wait_done(6000, de);
      begin
        repeat (6) @(negedge clk);
        start = 1'b1;
        byte_count = 16'd5;
        @(negedge clk);
        start = 1'b0;
      end
    join
    compare_beats("restart_ignored");
    chk("restart_checksum", checksum, exp_cks);

    // Randomized lengths, gaps and memory busy.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 70);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      busy_rand = r[0];
      run_load($sformatf("rnd%0d", r), r[1]);
    end
    busy_rand = 1'b0;

    // Reset asserted on beat 2 of a burst.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    got.delete();
    pulse_start(16);
    nb = 0;
    k = 0;
    fork
      feed(1'b0, 500, le);
      begin
        while (nb < 3 && k < 200) begin
          @(negedge clk);
          k++;
          if (mif.enable === 1'b1) nb++;
        end
      end
    join
    chk("rst_reached_beat2", 32'(nb), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("mrst_enable", 32'(mif.enable), 32'd0);
    chk("mrst_rw", 32'(mif.rw), 32'd0);
    chk("mrst_addr", mif.addr, 32'd0);
    chk("mrst_din", mif.din, 32'd0);
    chk("mrst_access_size", 32'(mif.access_size), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_loading", 32'(loading), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_checksum", checksum, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got.delete();
    repeat (30) @(negedge clk);
    chk("mrst_no_enable_after", 32'(got.size()), 32'd0);
    chk("mrst_loading_after", 32'(loading), 32'd0);

    chk("in_ready_outside_load", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
